// File: rtl/cnt_capture_if.sv
// cnt_capture_if: valid/ready read port carrying a captured value and its delta.
interface cnt_capture_if #(parameter int W = 8);
  logic         rd_valid;
  logic         rd_ready;
  logic [W-1:0] rd_data;
  logic [W-1:0] rd_delta;
  modport master (output rd_valid, rd_data, rd_delta, input rd_ready);
  modport slave (input rd_valid, rd_data, rd_delta, output rd_ready);
endinterface

// File: rtl/cnt_capture.sv
// cnt_capture: samples a counter on trigger pulses into a FWFT FIFO of {value, delta}.
module cnt_capture #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
)(
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic [W-1:0]  din,
  input  logic          trig,
  cnt_capture_if.master rd,
  output logic [AW:0]   level,
  output logic          ovf
);
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]    level_q, level_d;
  logic [W-1:0]   prev_q, prev_d, delta;
  logic           ovf_q, ovf_d, pop, push, full;
  logic [2*W-1:0] mem_q [DEPTH];
  always_comb begin
    pop      = rd.rd_valid & rd.rd_ready;
    full     = level_q == (AW+1)'(DEPTH);
    push     = trig & (~full | pop);
    delta    = din - prev_q;
    rd_ptr_d = clr ? '0 : rd_ptr_q + AW'(pop);
    wr_ptr_d = clr ? '0 : wr_ptr_q + AW'(push);
    level_d  = clr ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
    prev_d   = clr ? '0 : push ? din : prev_q;
    ovf_d    = ~clr & (ovf_q | (trig & full & ~pop));
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      prev_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      prev_q   <= prev_d;
      ovf_q    <= ovf_d;
    end
  // storage is never reset; stale entries are unreachable once level is 0
  always_ff @(posedge clk)
    if (push & ~clr) mem_q[wr_ptr_q] <= {din, delta};
  assign rd.rd_valid              = level_q != '0;
  assign {rd.rd_data, rd.rd_delta} = mem_q[rd_ptr_q];
  assign level                    = level_q;
  assign ovf                      = ovf_q;
endmodule

// File: tb/tb_cnt_capture.sv
// tb_cnt_capture: directed stimulus with a scoreboard queue checked by a pop monitor.
module tb_cnt_capture;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clr = 1'b0;
  logic       trig = 1'b0;
  logic [7:0] din = '0;
  logic [2:0] level;
  logic       ovf;
  logic [7:0] exp_prev = '0;
  logic [15:0] sb[$];
  logic [15:0] e;
  int runs = 0;
  int fails = 0;
  cnt_capture_if #(.W(8)) rd_if();
  cnt_capture #(.W(8), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .din(din), .trig(trig),
    .rd(rd_if.master), .level(level), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    runs++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask
  // exp_push: whether this trigger should be stored, decided by the test writer
  task automatic drive(input logic t, input logic [7:0] d, input logic r, input logic c, input logic exp_push);
    trig = t; din = d; rd_ready_set(r); clr = c;
    if (c) begin
      sb.delete();
      exp_prev = '0;
    end else if (exp_push) begin
      sb.push_back({d, 8'(d - exp_prev)});
      exp_prev = d;
    end
    @(posedge clk); #1;
  endtask
  task automatic rd_ready_set(input logic r);
    rd_if.rd_ready = r;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && !clr && rd_if.rd_valid && rd_if.rd_ready) begin
        if (sb.size() == 0) begin
          runs++;
          fails++;
          $display("FAIL unexpected_pop: got data 0x%0h, expected no entry", rd_if.rd_data);
        end else begin
          e = sb.pop_front();
          chk("rd_data", int'(rd_if.rd_data), int'(e[15:8]));
          chk("rd_delta", int'(rd_if.rd_delta), int'(e[7:0]));
        end
      end
    end
  end
  initial begin
    rd_if.rd_ready = 1'b0;
    #3;
    chk("reset_valid", int'(rd_if.rd_valid), 0);
    chk("reset_level", int'(level), 0);
    chk("reset_ovf", int'(ovf), 0);
    #20 rstn = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 8'h04, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b1);
    chk("single_valid", int'(rd_if.rd_valid), 1);
    chk("single_level", int'(level), 1);
    drive(1'b0, 8'h06, 1'b1, 1'b0, 1'b0);
    chk("single_pop_valid", int'(rd_if.rd_valid), 0);
    chk("single_pop_level", int'(level), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'hFD, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
    chk("wrap_level", int'(level), 2);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wrap_drained", int'(level), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(10 * i), 1'b0, 1'b0, 1'b1);
    chk("fill_ovf_before", int'(ovf), 0);
    drive(1'b1, 8'd50, 1'b0, 1'b0, 1'b0);
    chk("fill_level", int'(level), 4);
    chk("fill_ovf", int'(ovf), 1);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drain_level", int'(level), 0);
    chk("ovf_sticky", int'(ovf), 1);
    drive(1'b1, 8'd60, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", int'(ovf), 0);
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'd5, 1'b1, 1'b0, 1'b1);
    chk("full_pushpop_level", int'(level), 4);
    chk("full_pushpop_ovf", int'(ovf), 0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("full_pushpop_drained", int'(level), 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i + 20), 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'd30, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("pre_clr_level", int'(level), 3);
    chk("pre_clr_ovf", int'(ovf), 1);
    drive(1'b1, 8'd9, 1'b1, 1'b1, 1'b0);
    chk("clr_prio_level", int'(level), 0);
    chk("clr_prio_valid", int'(rd_if.rd_valid), 0);
    chk("clr_prio_ovf", int'(ovf), 0);
    drive(1'b1, 8'd7, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    trig = 1'b1; din = 8'd8; rd_if.rd_ready = 1'b1; clr = 1'b0;
    sb.push_back({8'd8, 8'(8'd8 - exp_prev)});
    exp_prev = 8'd8;
    #1 chk("empty_no_bypass", int'(rd_if.rd_valid), 0);
    @(posedge clk); #1;
    chk("empty_push_level", int'(level), 1);
    drive(1'b1, 8'h0A, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_level", int'(level), 2);
    #2 rstn = 1'b0;
    sb.delete();
    exp_prev = '0;
    #1;
    chk("async_valid", int'(rd_if.rd_valid), 0);
    chk("async_level", int'(level), 0);
    chk("async_ovf", int'(ovf), 0);
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("post_reset_valid", int'(rd_if.rd_valid), 0);
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("post_reset_level", int'(level), 0);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end
endmodule

// File: doc/cnt_capture.md
# cnt_capture

Capture stage downstream of the free-running counter block: it samples the counter's registered output on each trigger pulse and buffers the value, with the modulo-2^W delta from the previous capture, in a small first-word-fall-through FIFO. A consumer drains the FIFO through a valid/ready port. It shares the counter's clock, reset and synchronous clear, so one clear flushes both stages together.

## Interface
- W, 8: width of the counter value on din; also the width of rd_data and rd_delta
- DEPTH, 4: FIFO entries; must be a power of two and at least 2
- clk  in  1  system clock; all logic on the rising edge
- rstn  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear; the same net that clears the upstream counter
- din  in  W  counter value (the counter's registered dout)
- trig  in  1  capture request, one per cycle, sampled on the rising edge
- rd_valid  out  1  FIFO not empty; head entry is presented
- rd_ready  in  1  consumer accepts the head entry
- rd_data  out  W  captured counter value at the head
- rd_delta  out  W  head value minus previous captured value, modulo 2^W
- level  out  clog2(DEPTH)+1  number of stored entries
- ovf  out  1  sticky flag: at least one trigger was dropped

## Operation
- Push: trig=1 at an edge stores {din, din-prev} and updates prev to din. prev is a W-bit register with reset value 0.
- Delta arithmetic is W-bit unsigned subtraction with wrap-around. Example with W=8: din=0x03, prev=0xFD gives delta 0x06.
- Pop: rd_valid & rd_ready at an edge removes the head entry.
- Read pointer, write pointer and level are registers. Pointers wrap modulo DEPTH.
- Full (level==DEPTH), trig=1, no pop in that cycle:
  - The trigger is dropped.
  - prev is not updated.
  - ovf is set to 1.
- Full, trig=1, pop in the same cycle: push and pop both occur, level stays at DEPTH, ovf is unchanged.
- Empty, trig=1, rd_ready=1: only the push occurs. There is no bypass, so rd_valid is 0 during that cycle.
- clr=1 at an edge:
  - Pointers, level, prev and ovf go to 0.
  - clr has priority over trig and over pop in the same cycle; neither takes effect.
- ovf clears only on clr or reset.
- Pop of data already held in the FIFO is never blocked by ovf.
- Entry storage needs no reset; outputs are defined only while rd_valid=1.

## Timing
- Reset (rstn=0, asynchronous): rd_valid=0, level=0, ovf=0, prev=0, pointers=0 immediately, independent of clk.
- Deassertion of rstn is synchronised upstream; this block needs no extra handling for it.
- Latency: trig at edge N makes rd_valid=1 after edge N, and rd_data/rd_delta are valid in the same cycle.
- rd_data, rd_delta and rd_valid come from registers or a registered memory plus the read pointer, with no combinational path from trig or din. rd_valid depends only on level.
- rd_ready may depend combinationally on rd_valid; rd_valid must not depend on rd_ready.
- Throughput: one push and one pop per cycle are sustained indefinitely.
- level updates on the edge: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- rstn asserted mid-operation:
  - All state is discarded immediately.
  - Entries present before reset are never presented afterwards.
  - ovf reads 0 after reset.

## Test plan
- Reset then a single capture:
  - Release rstn and run the counter from 0.
  - Pulse trig when din=0x05 -> next cycle rd_valid=1, rd_data=0x05, rd_delta=0x05, level=1.
  - Pop with rd_ready=1 -> rd_valid=0, level=0.
- Delta wrap (W=8):
  - Capture at din=0xFD, then at din=0x03.
  - Required: second entry rd_delta=0x06; first entry rd_delta=0xFD (prev was 0).
- Fill and overflow (DEPTH=4, rd_ready=0):
  - Issue 5 triggers at din=10,20,30,40,50.
  - Required: level=4 and ovf=1.
  - Drain -> data 10,20,30,40 with deltas 10,10,10,10.
  - A following capture at 60 -> delta 20, because the dropped 50 did not update prev.
- Full with simultaneous push and pop:
  - With level=4, assert trig and rd_ready in the same cycle.
  - Required: level stays 4, ovf stays 0, head advances by one entry, new value lands at the tail.
- clr priority:
  - With level=3 and ovf=1, assert clr together with trig and rd_ready.
  - Required: next cycle level=0, rd_valid=0, ovf=0.
  - A following capture at din=7 -> rd_delta=7.
- Asynchronous reset mid-stream:
  - With level=2, drop rstn between clock edges.
  - Required: rd_valid=0 and level=0 before the next edge.
  - After release, no old entries appear and the first delta equals din.
